// File: rtl/delete_order_encoder.sv
// ITCH 5.0 Delete Order ('D') serializer: queued 64-bit order references leave as
// 9-byte messages (type byte, then reference MSB first), one byte per cycle.
module delete_order_encoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 0,
  parameter logic [7:0]  MSG_TYPE   = 8'h44,
  parameter int unsigned MSG_LENGTH = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enc_valid,
  output logic        enc_ready,
  input  logic [63:0] enc_order_ref,
  output logic [7:0]  byte_out,
  output logic        valid_out,
  input  logic        out_ready,
  output logic        msg_done,
  output logic [15:0] msg_count,
  output logic        busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = 4;
  localparam int unsigned GW = 4;
  localparam logic [IW-1:0] LAST_IDX = IW'(MSG_LENGTH - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : GW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Request queue
  logic [63:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] fifo_count_d;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [63:0]   head;

  assign push       = enc_valid && enc_ready;
  assign fifo_empty = (fifo_count == '0);
  assign head       = mem[rd_ptr];

  always_comb begin
    fifo_count_d = fifo_count;
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count + CW'(1);
      2'b01:   fifo_count_d = fifo_count - CW'(1);
      default: fifo_count_d = fifo_count;
    endcase
  end

  // enc_ready is registered from the next occupancy, so a full queue refuses
  // a request even when a pop happens on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      enc_ready  <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(push);
      rd_ptr     <= rd_ptr + AW'(pop);
      fifo_count <= fifo_count_d;
      enc_ready  <= (fifo_count_d < DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= enc_order_ref;
    end
  end

  // Serializer FSM
  state_t        state;
  state_t        state_d;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_d;
  logic [63:0]   sreg;
  logic [63:0]   sreg_d;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_cnt_d;
  logic [7:0]    byte_d;
  logic          valid_d;
  logic          done_d;
  logic [15:0]   count_d;
  logic          load;

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    sreg_d    = sreg;
    gap_cnt_d = gap_cnt;
    byte_d    = byte_out;
    valid_d   = valid_out;
    done_d    = 1'b0;
    count_d   = msg_count;
    load      = 1'b0;
    pop       = 1'b0;

    case (state)
      IDLE: begin
        load = !fifo_empty;
      end

      SEND: begin
        if (valid_out && out_ready) begin
          if (idx == LAST_IDX) begin
            done_d  = 1'b1;
            count_d = msg_count + 16'd1;
            byte_d  = 8'h00;
            valid_d = 1'b0;
            idx_d   = '0;
            if (GAP_CYCLES == 0) begin
              // Back-to-back: the next header replaces the last byte with no bubble.
              load    = !fifo_empty;
              state_d = IDLE;
            end else begin
              gap_cnt_d = '0;
              state_d   = GAP;
            end
          end else begin
            byte_d = sreg[63:56];
            sreg_d = {sreg[55:0], 8'h00};
            idx_d  = idx + IW'(1);
          end
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          load    = !fifo_empty;
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt + GW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      pop     = 1'b1;
      byte_d  = MSG_TYPE;
      valid_d = 1'b1;
      sreg_d  = head;
      idx_d   = '0;
      state_d = SEND;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      sreg      <= '0;
      gap_cnt   <= '0;
      byte_out  <= 8'h00;
      valid_out <= 1'b0;
      msg_done  <= 1'b0;
      msg_count <= 16'h0000;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      sreg      <= sreg_d;
      gap_cnt   <= gap_cnt_d;
      byte_out  <= byte_d;
      valid_out <= valid_d;
      msg_done  <= done_d;
      msg_count <= count_d;
      busy      <= !fifo_empty || (state != IDLE);
    end
  end

endmodule

// File: doc/delete_order_encoder.md
Name: delete_order_encoder

Overview:
Serializes ITCH 5.0 Delete Order ('D') messages into the one-byte-per-cycle stream format consumed by the speculative ITCH decoders. Each message is 9 bytes: type 0x44, then the 64-bit order reference, MSB first. Requests arrive on a valid/ready handshake and are buffered in a small FIFO. The output honours downstream backpressure. The block is used as a stimulus and loopback source and in the outbound feed path.

Parameters:
FIFO_DEPTH, 4, request queue depth; power of two, minimum 2.
GAP_CYCLES, 0, minimum idle cycles (valid_out low) inserted between consecutive messages; range 0..15.
MSG_TYPE, 8'h44, type byte emitted as byte 0.
MSG_LENGTH, 9, total bytes per message.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
enc_valid  in  1  request valid
enc_ready  out  1  request accepted when enc_valid && enc_ready at a rising edge
enc_order_ref  in  64  order reference to encode
byte_out  out  8  serialized ITCH byte
valid_out  out  1  byte_out valid
out_ready  in  1  downstream accepts byte when valid_out && out_ready
msg_done  out  1  one-cycle pulse per completed message
msg_count  out  16  count of completed messages, wraps
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Clocking and reset:
  - Single clock domain. rst_n is sampled only at clk rising edges.
  - While rst_n=0: byte_out=0, valid_out=0, msg_done=0, msg_count=0, busy=0. FIFO is flushed and the FSM is in IDLE.
  - enc_ready=0 during reset and =1 in the first cycle after reset releases.
- Input queue:
  - enc_ready = (fifo_count < FIFO_DEPTH), driven from registered state only, with no combinational path from enc_valid.
  - When full, the request is not taken even if a pop occurs in the same cycle.
  - Push and pop in the same cycle on a non-full FIFO leaves the count unchanged. Data is ordered FIFO.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head, load byte_out=MSG_TYPE and valid_out=1, latch the ref into a 64-bit shift register, set idx=0, go to SEND.
  - SEND: on valid_out && out_ready, advance idx. For idx 1..8, byte_out = ref[63-8*(idx-1) -: 8].
  - When byte idx=8 handshakes:
    - pulse msg_done for 1 cycle and increment msg_count (0xFFFF -> 0x0000).
    - If GAP_CYCLES=0 and the FIFO is non-empty, pop and load the next 0x44 at that same edge, giving no bubble and staying in SEND.
    - Else if GAP_CYCLES>0, go to GAP.
    - Else go to IDLE.
  - GAP: valid_out=0, count GAP_CYCLES cycles, then behave as IDLE.
- Output rules:
  - byte_out and valid_out are registered.
  - While valid_out && !out_ready, byte_out and valid_out hold stable.
  - byte_out=0 whenever valid_out=0.
  - valid_out never drops mid-message, and a message is never interleaved with another.
- Latency: a request accepted at edge E0 into an empty FIFO with the FSM in IDLE gives valid_out=1 / byte_out=0x44 after edge E1. With out_ready held at 1, the last byte is presented after edge E9, and msg_done is high after edge E10.
- Throughput: with GAP_CYCLES=0, a full FIFO and out_ready=1, valid_out stays continuously high and messages occupy exactly 9 cycles each.
- busy is registered. It is 1 from the edge after the first accept until the cycle after the final msg_done, and remains 1 during GAP.
- Reset mid-message: the partial message is abandoned, no msg_done is generated, and all queued requests are discarded.
- enc_order_ref=0 is legal and produces 0x44 followed by eight 0x00 bytes.

Test Plan:
1. Single request ref=64'h0123_4567_89AB_CDEF, out_ready=1 -> bytes 44 01 23 45 67 89 AB CD EF on 9 consecutive cycles starting 2 edges after accept; msg_done one pulse; msg_count=1; busy returns to 0.
2. Five back-to-back requests, FIFO_DEPTH=4, out_ready=1 -> enc_ready drops when the FIFO is full; 45 contiguous valid bytes with no bubbles; msg_count=5; refs emitted in order.
3. out_ready toggled pseudo-randomly during a message with ref=64'hFFFF_0000_FFFF_0000 -> byte_out/valid_out stable while stalled; byte sequence unchanged; msg_done only after byte 8 handshakes.
4. GAP_CYCLES=3, two queued requests -> exactly 3 cycles of valid_out=0 between byte 8 of message 1 and 0x44 of message 2.
5. rst_n=0 asserted at byte index 4 with 2 requests queued -> valid_out=0, msg_done never pulses, msg_count=0; the next request after release emits a clean 0x44-led message.
6. Loopback into the Delete Order decoder with 100 random refs -> the decoder raises internal_valid 100 times with matching order_ref; packet_invalid never asserts; msg_count=100.
